spi_flash_arbiter: RTL

- Shares the single configuration SPI flash bus (csn/sck/mosi/miso, sck later routed through USRMCLK) between two masters.
- Requester 0 is the USB bootloader's SPI engine; requester 1 is user logic, e.g. a config/bitstream reader.
- Grants whole transactions only: a granted master owns the bus from its first csn-low to its final csn-high.
- Inserts a guard gap between owners so the flash always sees a clean deselect.

---
 rtl/spi_flash_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: hands the configuration SPI flash bus to one of two masters, one whole transaction at a time.
// Optional build macro SPI_ARB_LOCK_EN adds lock_i so requester 0 can keep the bus across several transactions.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | bus free, flash deselected, arbitrating requests
// ST_OWN0  | requester 0 drives the flash pins
// ST_OWN1  | requester 1 drives the flash pins
// ST_GUARD | flash held deselected for GUARD_CYCLES before re-arbitration
module spi_flash_arbiter #(
  parameter int unsigned GUARD_CYCLES = 4,
  parameter logic [15:0] HOLD_LIMIT   = 16'd65535
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  input  logic [1:0] m_csn_i,
  input  logic [1:0] m_sck_i,
  input  logic [1:0] m_mosi_i,
  output logic [1:0] m_miso_o,
  output logic       flash_csn_o,
  output logic       flash_sck_o,
  output logic       flash_mosi_o,
  input  logic       flash_miso_i,
`ifdef SPI_ARB_LOCK_EN
  input  logic       lock_i,
`endif
  output logic       busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_GUARD = 2'd3
  } state_e;

  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        rr_q, rr_d;
  logic [7:0]  guard_cnt_q, guard_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]  blocked_q, blocked_d;

  logic        own_idx;
  logic        own_csn;
  logic        own_req;
  logic        own_lock;
  logic        release_ok;
  logic        hold_idle;
  logic        hold_hit;
  logic [1:0]  req_eff;

  // Owner-side view of the bus; only meaningful while in ST_OWN0/ST_OWN1.
  always_comb begin
    own_idx = (state_q == ST_OWN1);
    own_csn = m_csn_i[own_idx];
    own_req = req_i[own_idx];
`ifdef SPI_ARB_LOCK_EN
    own_lock = lock_i && (state_q == ST_OWN0);
`else
    own_lock = 1'b0;
`endif
    release_ok = !own_req && own_csn && !own_lock;
    hold_idle  = own_req && own_csn;
    hold_hit   = (HOLD_LIMIT != 16'd0) && hold_idle &&
                 (({1'b0, hold_cnt_q} + 17'd1) >= {1'b0, HOLD_LIMIT});
    // A requester kicked off by the hold limit stays masked until it drops req.
    req_eff    = req_i & ~blocked_q;
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    guard_cnt_d = guard_cnt_q;
    hold_cnt_d  = 16'd0;
    blocked_d   = blocked_q & req_i;

    unique case (state_q)
      ST_IDLE: begin
        unique case (req_eff)
          2'b01: begin
            state_d = ST_OWN0;
            gnt_d   = 2'b01;
          end
          2'b10: begin
            state_d = ST_OWN1;
            gnt_d   = 2'b10;
          end
          2'b11: begin
            state_d = rr_q ? ST_OWN1 : ST_OWN0;
            gnt_d   = rr_q ? 2'b10 : 2'b01;
            rr_d    = ~rr_q;
          end
          default: ;
        endcase
      end

      ST_OWN0, ST_OWN1: begin
        if (release_ok || hold_hit) begin
          state_d     = ST_GUARD;
          gnt_d       = 2'b00;
          guard_cnt_d = GUARD_LOAD;
          if (hold_hit) begin
            blocked_d[own_idx] = 1'b1;
          end
        end else if (!own_csn) begin
          hold_cnt_d = 16'd0;
        end else if (hold_idle && (HOLD_LIMIT != 16'd0) && (hold_cnt_q != 16'hFFFF)) begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end

      ST_GUARD: begin
        gnt_d = 2'b00;
        if (guard_cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 2'b00;
      rr_q        <= 1'b0;
      guard_cnt_q <= 8'd0;
      hold_cnt_q  <= 16'd0;
      blocked_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      guard_cnt_q <= guard_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      blocked_q   <= blocked_d;
    end
  end

  // Pin mux is steered only by registered state, so a reset deselects the flash at once.
  always_comb begin
    flash_csn_o  = 1'b1;
    flash_sck_o  = 1'b0;
    flash_mosi_o = 1'b0;
    m_miso_o     = 2'b00;
    unique case (state_q)
      ST_OWN0: begin
        flash_csn_o  = m_csn_i[0];
        flash_sck_o  = m_sck_i[0];
        flash_mosi_o = m_mosi_i[0];
        m_miso_o     = {1'b0, flash_miso_i};
      end
      ST_OWN1: begin
        flash_csn_o  = m_csn_i[1];
        flash_sck_o  = m_sck_i[1];
        flash_mosi_o = m_mosi_i[1];
        m_miso_o     = {flash_miso_i, 1'b0};
      end
      default: ;
    endcase
  end

  assign gnt_o  = gnt_q;
  assign busy_o = (state_q != ST_IDLE);

endmodule
